// File: rtl/bcp_pkg.sv
// bcp_pkg: shared types and helpers for the BCP priority scanner.
// The optional round-robin pick is enabled by defining BCP_PSCAN_ROUND_ROBIN_EN.
package bcp_pkg;

  typedef enum logic [1:0] {PS_IDLE, PS_EMIT, PS_DONE} pscan_state_t;

  // Widest vector the scanner supports; helpers take vectors zero-extended to this.
  localparam int PSCAN_MAX_WIDTH = 256;

  // True when exactly one bit of v is set.
  function automatic logic popcount_is_one(input logic [PSCAN_MAX_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - PSCAN_MAX_WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/bcp_pe_core.sv
// bcp_pe_core: combinational priority encoder. Returns the first set bit of vec
// found scanning downward from start, wrapping from 0 to WIDTH-1.
// Used by bcp_priority_scanner (round-robin start under BCP_PSCAN_ROUND_ROBIN_EN).
module bcp_pe_core #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk from farthest to nearest position so the nearest set bit wins.
  always_comb begin
    int pos;
    pos = 0;
    idx = '0;
    any = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      pos = int'(start) - i;
      if (pos < 0) pos = pos + WIDTH;
      if (vec[pos]) idx = IDX_W'(pos);
    end
  end

endmodule

// File: rtl/bcp_priority_scanner.sv
// bcp_priority_scanner: captures a flag vector and emits the index of every set
// bit, one per accepted beat, then pulses done.
// Define BCP_PSCAN_ROUND_ROBIN_EN for a persistent round-robin start pointer;
// otherwise priority is fixed, highest index first.
//
//  state   | meaning
//  PS_IDLE | waiting for in_valid; in_ready=1
//  PS_EMIT | idx_valid=1, presenting the current pick of pending
//  PS_DONE | done pulse for one cycle, then back to idle
module bcp_priority_scanner
  import bcp_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             idx_last,
  output logic             done,
  output logic             done_empty
);

  pscan_state_t     state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_out_d;
  logic             idx_valid_d, idx_last_d, done_d, done_empty_d, in_ready_d;

  logic             beat;
  logic [WIDTH-1:0] cleared;
  logic [WIDTH-1:0] core_vec;
  logic [IDX_W-1:0] core_start;
  logic [IDX_W-1:0] core_idx;
  logic             core_any;

  assign beat     = idx_valid & idx_ready;
  assign cleared  = pending_q & ~(WIDTH'(1) << idx_out);
  // Idle picks from the incoming vector; emit picks the successor of the current index.
  assign core_vec = (state_q == PS_IDLE) ? in_vec : cleared;

`ifdef BCP_PSCAN_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;

  assign rr_next    = (idx_out == '0) ? IDX_W'(WIDTH - 1) : idx_out - IDX_W'(1);
  assign core_start = (state_q == PS_IDLE) ? rr_ptr : rr_next;

  // Pointer advances on every consumed beat, including one that coincides with flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     rr_ptr <= IDX_W'(WIDTH - 1);
    else if (beat) rr_ptr <= rr_next;
  end
`else
  assign core_start = IDX_W'(WIDTH - 1);
`endif

  bcp_pe_core #(.WIDTH(WIDTH)) u_pe_core (
    .vec   (core_vec),
    .start (core_start),
    .idx   (core_idx),
    .any   (core_any)
  );

  // State register plus all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= PS_IDLE;
      pending_q  <= '0;
      idx_out    <= '0;
      idx_valid  <= 1'b0;
      idx_last   <= 1'b0;
      done       <= 1'b0;
      done_empty <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      idx_out    <= idx_out_d;
      idx_valid  <= idx_valid_d;
      idx_last   <= idx_last_d;
      done       <= done_d;
      done_empty <= done_empty_d;
      in_ready   <= in_ready_d;
    end
  end

  // Next-state and next-output decode; flush overrides everything else.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    idx_out_d    = idx_out;
    idx_valid_d  = idx_valid;
    idx_last_d   = idx_last;
    done_d       = 1'b0;
    done_empty_d = 1'b0;
    if (flush) begin
      state_d     = PS_IDLE;
      pending_d   = '0;
      idx_valid_d = 1'b0;
      idx_last_d  = 1'b0;
    end else begin
      case (state_q)
        PS_IDLE: begin
          if (in_valid) begin
            if (core_any) begin
              state_d     = PS_EMIT;
              pending_d   = in_vec;
              idx_out_d   = core_idx;
              idx_last_d  = popcount_is_one(PSCAN_MAX_WIDTH'(in_vec));
              idx_valid_d = 1'b1;
            end else begin
              state_d      = PS_DONE;
              done_d       = 1'b1;
              done_empty_d = 1'b1;
            end
          end
        end
        PS_EMIT: begin
          if (idx_ready) begin
            pending_d = cleared;
            if (idx_last) begin
              state_d     = PS_DONE;
              idx_valid_d = 1'b0;
              idx_last_d  = 1'b0;
              done_d      = 1'b1;
            end else begin
              idx_out_d  = core_idx;
              idx_last_d = popcount_is_one(PSCAN_MAX_WIDTH'(cleared));
            end
          end
        end
        PS_DONE: state_d = PS_IDLE;
        default: state_d = PS_IDLE;
      endcase
    end
    in_ready_d = (state_d == PS_IDLE);
  end

endmodule

// File: tb/tb_bcp_priority_scanner.sv
// tb_bcp_priority_scanner: directed table, hand sequences and randomized scans
// against a list-based reference model. Honours BCP_PSCAN_ROUND_ROBIN_EN.
module tb_bcp_priority_scanner;

  logic       clock = 1'b0;
  logic       reset, flush;
  logic [7:0] in_vec;
  logic       in_valid, in_ready;
  logic [2:0] idx_out;
  logic       idx_valid, idx_ready, idx_last, done, done_empty;

  logic [36:0] in_vec37;
  logic        in_valid37, in_ready37;
  logic [5:0]  idx_out37;
  logic        idx_valid37, idx_ready37, idx_last37, done37, done_empty37;

  int total = 0;
  int bad   = 0;
  int rr_model = 7;
  int exp_q[$];

  typedef struct packed {
    logic [7:0]      vec;
    logic [3:0]      n;
    logic [0:7][2:0] seq;
  } vec_t;
  vec_t tbl[6];

  bcp_priority_scanner #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready), .idx_out(idx_out), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx_last(idx_last), .done(done), .done_empty(done_empty)
  );

  bcp_priority_scanner #(.WIDTH(37)) dut37 (
    .clock(clock), .reset(reset), .flush(flush), .in_vec(in_vec37), .in_valid(in_valid37),
    .in_ready(in_ready37), .idx_out(idx_out37), .idx_valid(idx_valid37), .idx_ready(idx_ready37),
    .idx_last(idx_last37), .done(done37), .done_empty(done_empty37)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; idx_ready = 1'b0;
    in_valid37 = 1'b0; idx_ready37 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    rr_model = 7;
  endtask

  // Expected emission order: set bits in circular descending order from the start pointer.
  function automatic void build_exp(input logic [7:0] v);
    int ptr;
    int p;
`ifdef BCP_PSCAN_ROUND_ROBIN_EN
    ptr = rr_model;
`else
    ptr = 7;
`endif
    exp_q.delete();
    for (int j = 0; j < 8; j++) begin
      p = (ptr - j + 8) % 8;
      if (v[p]) exp_q.push_back(p);
    end
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, " idx_out"}, idx_out, 0);
    chk({tag, " idx_valid"}, idx_valid, 0);
    chk({tag, " idx_last"}, idx_last, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " done_empty"}, done_empty, 0);
    chk({tag, " in_ready"}, in_ready, 1);
  endtask

  // Full scan of one vector with random back-pressure, checked against the model.
  task automatic scan8(input logic [7:0] v, input int stall_pct, input string tag);
    int k, guard, n;
    build_exp(v);
    n = exp_q.size();
    guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    chk({tag, " in_ready before capture"}, in_ready, 1);
    in_vec = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_vec = 8'($urandom);
    if (n == 0) begin
      chk({tag, " empty idx_valid"}, idx_valid, 0);
      chk({tag, " empty done"}, done, 1);
      chk({tag, " empty done_empty"}, done_empty, 1);
      chk({tag, " empty in_ready"}, in_ready, 0);
      tick();
      chk({tag, " empty done pulse end"}, done, 0);
      chk({tag, " empty in_ready after"}, in_ready, 1);
      return;
    end
    k = 0; guard = 0;
    while (k < n && guard < 200) begin
      chk({tag, " idx_valid"}, idx_valid, 1);
      chk({tag, " idx_out"}, idx_out, exp_q[k]);
      chk({tag, " idx_last"}, idx_last, (k == n - 1) ? 1 : 0);
      chk({tag, " done early"}, done, 0);
      chk({tag, " in_ready busy"}, in_ready, 0);
      idx_ready = ($urandom_range(99) >= stall_pct);
      tick();
      if (idx_ready) k++;
      guard++;
    end
    if (k < n) chk({tag, " beat timeout"}, k, n);
    idx_ready = 1'b0;
    chk({tag, " done"}, done, 1);
    chk({tag, " done_empty"}, done_empty, 0);
    chk({tag, " idx_valid after last"}, idx_valid, 0);
    chk({tag, " in_ready during done"}, in_ready, 0);
`ifdef BCP_PSCAN_ROUND_ROBIN_EN
    rr_model = (exp_q[n-1] == 0) ? 7 : exp_q[n-1] - 1;
`endif
    tick();
    chk({tag, " done pulse end"}, done, 0);
    chk({tag, " in_ready after done"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_vec = '0; in_vec37 = '0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; idx_ready = 1'b0;
    in_valid37 = 1'b0; idx_ready37 = 1'b0;
    #2;
    check_reset_values("por");
    do_reset();
    check_reset_values("after reset");

    tbl[0] = '{vec: 8'hA4, n: 4'd3, seq: {3'd7, 3'd5, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[1] = '{vec: 8'h00, n: 4'd0, seq: '0};
    tbl[2] = '{vec: 8'h81, n: 4'd2, seq: {3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[3] = '{vec: 8'h01, n: 4'd1, seq: '0};
    tbl[4] = '{vec: 8'hFF, n: 4'd8, seq: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    tbl[5] = '{vec: 8'h42, n: 4'd2, seq: {3'd6, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};

    // Directed table, continuous idx_ready, fresh reset per vector.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      in_vec = tbl[t].vec; in_valid = 1'b1; idx_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < int'(tbl[t].n); k++) begin
        chk($sformatf("tbl%0d idx_valid", t), idx_valid, 1);
        chk($sformatf("tbl%0d idx_out[%0d]", t, k), idx_out, tbl[t].seq[k]);
        chk($sformatf("tbl%0d idx_last[%0d]", t, k), idx_last, (k == int'(tbl[t].n) - 1) ? 1 : 0);
        tick();
      end
      idx_ready = 1'b0;
      chk($sformatf("tbl%0d done", t), done, 1);
      chk($sformatf("tbl%0d done_empty", t), done_empty, (tbl[t].n == 0) ? 1 : 0);
      chk($sformatf("tbl%0d idx_valid end", t), idx_valid, 0);
      tick();
      chk($sformatf("tbl%0d done end", t), done, 0);
      chk($sformatf("tbl%0d in_ready end", t), in_ready, 1);
    end

    // Asynchronous reset in the middle of an emit.
    do_reset();
    in_vec = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; idx_ready = 1'b1;
    tick();
    chk("midreset pre idx_out", idx_out, 6);
    #1 reset = 1'b1;
    #1;
    check_reset_values("midreset async");
    reset = 1'b0; idx_ready = 1'b0; rr_model = 7;
    tick();
    chk("midreset idx_valid", idx_valid, 0);
    chk("midreset no done", done, 0);
    tick();
    chk("midreset no done later", done, 0);
    chk("midreset in_ready", in_ready, 1);

    // Single bit held under back-pressure.
    do_reset();
    in_vec = 8'h80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall idx_out c%0d", c), idx_out, 7);
      chk($sformatf("stall idx_last c%0d", c), idx_last, 1);
      chk($sformatf("stall idx_valid c%0d", c), idx_valid, 1);
      chk($sformatf("stall done c%0d", c), done, 0);
      tick();
    end
    idx_ready = 1'b1;
    chk("stall release idx_out", idx_out, 7);
    tick();
    idx_ready = 1'b0;
    chk("stall done", done, 1);
    chk("stall idx_valid off", idx_valid, 0);
`ifdef BCP_PSCAN_ROUND_ROBIN_EN
    rr_model = 6;
`endif
    tick();
    chk("stall done end", done, 0);

    // Flush after two beats, then a fresh vector.
    do_reset();
    in_vec = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; idx_ready = 1'b1;
    chk("flush beat0", idx_out, 7);
    tick();
    chk("flush beat1", idx_out, 6);
    tick();
    chk("flush pre", idx_out, 5);
    flush = 1'b1; idx_ready = 1'b0;
    tick();
    flush = 1'b0;
`ifdef BCP_PSCAN_ROUND_ROBIN_EN
    rr_model = 5;
`endif
    chk("flush in_ready", in_ready, 1);
    chk("flush idx_valid", idx_valid, 0);
    chk("flush idx_last", idx_last, 0);
    chk("flush no done", done, 0);
    tick();
    chk("flush no done later", done, 0);
    scan8(8'h81, 0, "after flush 81");

    // Flush while idle with a valid request: no capture.
    flush = 1'b1; in_vec = 8'hFF; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("idle flush in_ready", in_ready, 1);
    chk("idle flush idx_valid", idx_valid, 0);
    chk("idle flush done", done, 0);
    tick();
    chk("idle flush idx_valid later", idx_valid, 0);
    chk("idle flush done later", done, 0);

    // Randomized scans with back-pressure.
    for (int r = 0; r < 40; r++) begin
      logic [7:0] v;
      v = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      scan8(v, 30, $sformatf("rand%0d", r));
    end

    // WIDTH=37: highest and lowest lanes.
    do_reset();
    in_vec37 = 37'h10_0000_0001; in_valid37 = 1'b1;
    tick();
    in_valid37 = 1'b0; idx_ready37 = 1'b1;
    chk("w37 idx_valid", idx_valid37, 1);
    chk("w37 idx_out0", idx_out37, 36);
    chk("w37 idx_last0", idx_last37, 0);
    tick();
    chk("w37 idx_out1", idx_out37, 0);
    chk("w37 idx_last1", idx_last37, 1);
    tick();
    idx_ready37 = 1'b0;
    chk("w37 done", done37, 1);
    chk("w37 done_empty", done_empty37, 0);
    chk("w37 idx_valid end", idx_valid37, 0);
    tick();
    chk("w37 in_ready", in_ready37, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
